bcd_serial_addsub: RTL and testbench

- Multi-digit BCD adder-subtracter controller, one step upstream of the single-digit BCD adder-subtracter stage.
- Accepts two DIGITS-wide packed BCD operands and runs them through a digit-serial add/subtract datapath, LSB digit first.
- Propagates a registered decimal carry between digits and adds a tens-complement fix-up pass when a subtraction result is negative.
- Produces a sign-magnitude BCD result with a single-cycle done pulse.

---
 rtl/bcd_serial_addsub_if.sv | 26 ++
 rtl/bcd_serial_addsub.sv | 171 +++++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_addsub_if.sv
// Request/result bundle for the digit-serial BCD adder-subtracter.
// The requester drives start/Op/A/B; the controller returns status and the packed BCD result.
interface bcd_serial_addsub_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  Op;
  logic [4*DIGITS-1:0]   A;
  logic [4*DIGITS-1:0]   B;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   S;
  logic                  Cout;
  logic                  Neg;
  logic                  Err;

  modport master (
    output start, Op, A, B,
    input  busy, done, S, Cout, Neg, Err
  );

  modport slave (
    input  start, Op, A, B,
    output busy, done, S, Cout, Neg, Err
  );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Multi-digit BCD add/subtract controller: one digit per cycle, LSB first, with a
// tens-complement fix-up pass that turns a negative difference into sign-magnitude.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  bcd_serial_addsub_if.slave  bus
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    FIX,
    DONE
  } state_t;

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     s_q;
  logic             op_q;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             neg_q;
  logic             err_q;

  // Digit-step datapath signals
  logic [3:0] a_dig;
  logic [3:0] b_dig;
  logic [3:0] s_dig;
  logic [3:0] x_opnd;
  logic [3:0] y_opnd;
  logic [4:0] sum;
  logic [4:0] sum_adj;
  logic [3:0] dig_out;
  logic       carry_out;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    has_bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) has_bad_digit = 1'b1;
    end
  endfunction

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    a_dig   = a_q[4*idx +: 4];
    b_dig   = b_q[4*idx +: 4];
    s_dig   = s_q[4*idx +: 4];
    x_opnd  = a_dig;
    y_opnd  = op_q ? (4'd9 - b_dig) : b_dig;
    if (state == FIX) begin
      x_opnd = 4'd9 - s_dig;
      y_opnd = 4'd0;
    end
    sum       = {1'b0, x_opnd} + {1'b0, y_opnd} + {4'b0000, carry};
    sum_adj   = sum - 5'd10;
    dig_out   = sum[3:0];
    carry_out = 1'b0;
    if (sum > 5'd9) begin
      dig_out   = sum_adj[3:0];
      carry_out = 1'b1;
    end
  end

  // NOTE: all state and registered outputs update with non-blocking assignments so every
  // read in this block sees the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      op_q   <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cout_q <= 1'b0;
      neg_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.A;
            b_q    <= bus.B;
            op_q   <= bus.Op;
            s_q    <= '0;
            cout_q <= 1'b0;
            neg_q  <= 1'b0;
            idx    <= '0;
            carry  <= bus.Op;
            busy_q <= 1'b1;
            if (has_bad_digit(bus.A) || has_bad_digit(bus.B)) begin
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              err_q <= 1'b0;
              state <= ADD;
            end
          end
        end

        ADD: begin
          s_q[4*idx +: 4] <= dig_out;
          carry           <= carry_out;
          if (idx == LAST_IDX) begin
            idx <= '0;
            if (!op_q) begin
              cout_q <= carry_out;
              done_q <= 1'b1;
              state  <= DONE;
            end else if (carry_out) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              // Borrow out of the MSB: the digits hold the tens complement of |A-B|.
              neg_q <= 1'b1;
              carry <= 1'b1;
              state <= FIX;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end

        FIX: begin
          s_q[4*idx +: 4] <= dig_out;
          carry           <= carry_out;
          if (idx == LAST_IDX) begin
            idx    <= '0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          // The invalid-digit path arrives with done clear and spends one cycle raising it.
          if (!done_q) begin
            done_q <= 1'b1;
          end else begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.Neg  = neg_q;
  assign bus.Err  = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub (DIGITS=4): vector table plus hand-written
// sequences for held/mid-operation start and asynchronous reset.
module tb_bcd_serial_addsub;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int BUDGET = 40;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         cout;
    logic         neg;
    logic         err;
    int           lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs[12];

  bcd_serial_addsub_if #(.DIGITS(DIGITS)) bus();

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request before an edge and drop start just after it (the accept edge E0).
  task automatic apply_start(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges until done is seen; busy must stay high the whole way.
  task automatic wait_done(output int lat, output logic busy_ok);
    logic seen;
    seen    = 1'b0;
    busy_ok = 1'b1;
    lat     = BUDGET + 1;
    for (int i = 1; i <= BUDGET && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat, input logic busy_ok);
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " busy"}, {31'b0, busy_ok}, 32'd1);
    check({tag, " S"}, 32'(bus.S), 32'(v.s));
    check({tag, " Cout"}, {31'b0, bus.Cout}, {31'b0, v.cout});
    check({tag, " Neg"}, {31'b0, bus.Neg}, {31'b0, v.neg});
    check({tag, " Err"}, {31'b0, bus.Err}, {31'b0, v.err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic busy_ok;
    vec_t v;

    //          op    A         B         S         Cout  Neg   Err   lat
    vecs[0]  = '{1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b0, 4};
    vecs[1]  = '{1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 4};
    vecs[2]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4};
    vecs[3]  = '{1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b0, 1'b0, 1'b0, 4};
    vecs[4]  = '{1'b1, 16'h1234, 16'h5000, 16'h3766, 1'b0, 1'b1, 1'b0, 8};
    vecs[5]  = '{1'b1, 16'h4321, 16'h4321, 16'h0000, 1'b0, 1'b0, 1'b0, 4};
    vecs[6]  = '{1'b0, 16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
    vecs[7]  = '{1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 4};
    vecs[8]  = '{1'b0, 16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0, 1'b0, 4};
    vecs[9]  = '{1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, 8};
    vecs[10] = '{1'b1, 16'h0100, 16'h00F0, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
    vecs[11] = '{1'b0, 16'h4567, 16'h4444, 16'h9011, 1'b0, 1'b0, 1'b0, 4};

    bus.start = 1'b0;
    bus.Op    = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'b0, bus.busy}, 32'd0);
    check("reset done", {31'b0, bus.done}, 32'd0);
    check("reset S", 32'(bus.S), 32'd0);
    check("reset flags", {29'b0, bus.Cout, bus.Neg, bus.Err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 12; k++) begin
      v = vecs[k];
      apply_start(v.op, v.a, v.b);
      wait_done(lat, busy_ok);
      check_result($sformatf("vec%0d", k), v, lat, busy_ok);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d done pulse width", k), {31'b0, bus.done}, 32'd0);
      check($sformatf("vec%0d idle busy", k), {31'b0, bus.busy}, 32'd0);
      check($sformatf("vec%0d S held", k), 32'(bus.S), 32'(v.s));
    end

    // start held high: ignored in the DONE cycle, re-accepted the cycle after.
    v = vecs[0];
    @(negedge clk);
    bus.start = 1'b1;
    bus.Op    = v.op;
    bus.A     = v.a;
    bus.B     = v.b;
    @(posedge clk);
    #1;
    wait_done(lat, busy_ok);
    check_result("held first", v, lat, busy_ok);
    @(posedge clk);
    #1;
    check("held not accepted in done", {31'b0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    check("held second accept", {31'b0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    wait_done(lat, busy_ok);
    check_result("held second", v, lat, busy_ok);
    @(posedge clk);
    #1;
    check("held final idle", {31'b0, bus.busy}, 32'd0);

    // start pulsed with different operands mid-operation: no effect.
    apply_start(1'b0, 16'h1234, 16'h5678);
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.Op    = 1'b1;
    bus.A     = 16'h9999;
    bus.B     = 16'h0001;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    v = vecs[0];
    v.lat = 2;
    wait_done(lat, busy_ok);
    check_result("mid pulse", v, lat, busy_ok);
    @(posedge clk);
    #1;

    // Asynchronous reset while digit 2 is being added.
    apply_start(1'b0, 16'h1234, 16'h5678);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre-reset partial S", 32'(bus.S), 32'h0012);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset busy", {31'b0, bus.busy}, 32'd0);
    check("async reset S", 32'(bus.S), 32'd0);
    check("async reset flags", {28'b0, bus.done, bus.Cout, bus.Neg, bus.Err}, 32'd0);
    busy_ok = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) busy_ok = 1'b0;
    end
    check("no done during reset", {31'b0, busy_ok}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    v = '{1'b0, 16'h0005, 16'h0005, 16'h0010, 1'b0, 1'b0, 1'b0, 4};
    apply_start(v.op, v.a, v.b);
    wait_done(lat, busy_ok);
    check_result("post reset", v, lat, busy_ok);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
